// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-controller bus. The master side (pipeline) drives i_* and the slave side (controller) drives o_*.
interface pipeline_hazard_ctrl_if #(
  parameter int RegAddrBits = 5,
  parameter int CntBits = 16
);
  logic                   i_tick;
  logic [RegAddrBits-1:0] i_id_rs;
  logic [RegAddrBits-1:0] i_id_rt;
  logic                   i_id_uses_rt;
  logic                   i_id_mdu_op;
  logic                   i_ex_mem_read;
  logic [RegAddrBits-1:0] i_ex_rd;
  logic                   i_ex_branch_taken;
  logic                   o_pc_en;
  logic                   o_ifid_en;
  logic                   o_idex_en;
  logic                   o_ifid_flush;
  logic                   o_idex_flush;
  logic                   o_mdu_busy;
  logic [CntBits-1:0]     o_stall_cycles;
  modport master (
    output i_tick, i_id_rs, i_id_rt, i_id_uses_rt, i_id_mdu_op, i_ex_mem_read, i_ex_rd, i_ex_branch_taken,
    input  o_pc_en, o_ifid_en, o_idex_en, o_ifid_flush, o_idex_flush, o_mdu_busy, o_stall_cycles
  );
  modport slave (
    input  i_tick, i_id_rs, i_id_rt, i_id_uses_rt, i_id_mdu_op, i_ex_mem_read, i_ex_rd, i_ex_branch_taken,
    output o_pc_en, o_ifid_en, o_idex_en, o_ifid_flush, o_idex_flush, o_mdu_busy, o_stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: generates the pipeline-register enables and flushes for load-use, branch and MDU hazards, with an optional stall counter (STALL_COUNTER_EN); ports are i_clk, i_rst and the slave modport of pipeline_hazard_ctrl_if.
module pipeline_hazard_ctrl #(
  parameter int RegAddrBits = 5,
  parameter int MduLatency = 32,
  parameter int CntBits = 16
) (
  input logic i_clk,
  input logic i_rst,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, MDU_WAIT} state_t;
  state_t r_state;
  logic [CntBits-1:0] r_cnt;
  logic w_load_use, w_run, w_go;
  always_comb begin
    w_load_use = bus.i_ex_mem_read && bus.i_ex_rd != RegAddrBits'(0) &&
                 (bus.i_ex_rd == bus.i_id_rs || (bus.i_id_uses_rt && bus.i_ex_rd == bus.i_id_rt));
    w_run = !i_rst && bus.i_tick && r_state == RUN;
    w_go = w_run && (bus.i_ex_branch_taken || !w_load_use);
    bus.o_pc_en = w_go;
    bus.o_ifid_en = w_go;
    bus.o_idex_en = w_run;
    bus.o_ifid_flush = i_rst || (w_run && bus.i_ex_branch_taken);
    bus.o_idex_flush = i_rst || (w_run && (bus.i_ex_branch_taken || w_load_use));
    bus.o_mdu_busy = !i_rst && r_state == MDU_WAIT;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_cnt <= '0;
    end else if (bus.i_tick) begin
      if (r_state == RUN) begin
        if (!bus.i_ex_branch_taken && !w_load_use && bus.i_id_mdu_op) begin
          r_state <= MDU_WAIT;
          r_cnt <= CntBits'(MduLatency - 1);
        end
      end else if (r_cnt == '0) r_state <= RUN;
      else r_cnt <= r_cnt - 1'b1;
    end
  end
`ifdef STALL_COUNTER_EN
  logic [CntBits-1:0] r_stall;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_stall <= '0;
    else if (bus.i_tick && !bus.o_pc_en && r_stall != '1) r_stall <= r_stall + 1'b1;
  end
  assign bus.o_stall_cycles = r_stall;
`else
  assign bus.o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed-vector bench for pipeline_hazard_ctrl with CntBits=4 and MduLatency=4.
module tb_pipeline_hazard_ctrl;
  localparam bit has_cnt =
`ifdef STALL_COUNTER_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int busy_ticks;
  pipeline_hazard_ctrl_if #(.RegAddrBits(5), .CntBits(4)) bus ();
  pipeline_hazard_ctrl #(.RegAddrBits(5), .MduLatency(4), .CntBits(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] outs();
    return {bus.o_pc_en, bus.o_ifid_en, bus.o_idex_en, bus.o_ifid_flush, bus.o_idex_flush, bus.o_mdu_busy};
  endfunction
  function automatic logic [31:0] st(input int v);
    return has_cnt ? 32'(v) : 32'd0;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.i_tick = 1'b1;
    bus.i_id_rs = '0;
    bus.i_id_rt = '0;
    bus.i_id_uses_rt = 1'b0;
    bus.i_id_mdu_op = 1'b0;
    bus.i_ex_mem_read = 1'b0;
    bus.i_ex_rd = '0;
    bus.i_ex_branch_taken = 1'b0;
  endtask
  initial begin
    idle();
    #1;
    chk("reset_outs", 32'(outs()), 32'b000110);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("run_outs", 32'(outs()), 32'b111000);
    chk("run_stall", 32'(bus.o_stall_cycles), 32'd0);
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_rd = 5'd5;
    bus.i_id_rs = 5'd5;
    #1;
    chk("lu_rs_outs", 32'(outs()), 32'b001010);
    step();
    chk("lu_rs_stall", 32'(bus.o_stall_cycles), st(1));
    bus.i_ex_rd = 5'd0;
    bus.i_id_rs = 5'd0;
    #1;
    chk("lu_r0_outs", 32'(outs()), 32'b111000);
    step();
    chk("lu_r0_stall", 32'(bus.o_stall_cycles), st(1));
    bus.i_ex_rd = 5'd5;
    bus.i_id_rs = 5'd3;
    bus.i_id_rt = 5'd5;
    #1;
    chk("lu_rt_unused", 32'(outs()), 32'b111000);
    bus.i_id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used", 32'(outs()), 32'b001010);
    step();
    chk("lu_rt_stall", 32'(bus.o_stall_cycles), st(2));
    bus.i_ex_branch_taken = 1'b1;
    bus.i_id_mdu_op = 1'b1;
    #1;
    chk("br_lu_outs", 32'(outs()), 32'b111110);
    step();
    chk("br_lu_stall", 32'(bus.o_stall_cycles), st(2));
    chk("br_no_mdu", 32'(bus.o_mdu_busy), 32'd0);
    bus.i_ex_branch_taken = 1'b0;
    bus.i_id_mdu_op = 1'b0;
    bus.i_tick = 1'b0;
    #1;
    chk("notick_outs", 32'(outs()), 32'b000000);
    step();
    chk("notick_stall", 32'(bus.o_stall_cycles), st(2));
    idle();
    bus.i_id_mdu_op = 1'b1;
    #1;
    chk("mdu_issue", 32'(outs()), 32'b111000);
    step();
    bus.i_id_mdu_op = 1'b0;
    bus.i_ex_branch_taken = 1'b1;
    busy_ticks = 0;
    for (int i = 0; i < 12; i++) begin
      bus.i_tick = (i % 2 == 0);
      #1;
      if (bus.i_tick && bus.o_mdu_busy) begin
        busy_ticks++;
        chk("mdu_frozen", 32'(outs()), 32'b000001);
      end
      step();
    end
    chk("mdu_busy_ticks", 32'(busy_ticks), 32'd4);
    chk("mdu_stall", 32'(bus.o_stall_cycles), st(6));
    idle();
    #1;
    chk("mdu_back_run", 32'(outs()), 32'b111000);
    bus.i_id_mdu_op = 1'b1;
    step();
    bus.i_id_mdu_op = 1'b0;
    chk("mdu2_busy", 32'(outs()), 32'b000001);
    step();
    rst = 1'b1;
    #1;
    chk("mdu_rst_outs", 32'(outs()), 32'b000110);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_outs", 32'(outs()), 32'b111000);
    chk("post_rst_stall", 32'(bus.o_stall_cycles), 32'd0);
    bus.i_ex_mem_read = 1'b1;
    bus.i_ex_rd = 5'd7;
    bus.i_id_rs = 5'd7;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", 32'(bus.o_stall_cycles), st(14));
    for (int i = 0; i < 5; i++) step();
    chk("sat_15", 32'(bus.o_stall_cycles), st(15));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
